// File: rtl/bolge_sirala.sv
// Request sequencer for the bolge region decoder: queues {mode, region} requests
// and presents each one on Y/G/R for a programmable dwell, then a blanking gap.
module bolge_sirala #(
  parameter int DEPTH      = 4,
  parameter int DWELL_W    = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_mode,
  input  logic [1:0]               req_region,
  input  logic [DWELL_W-1:0]       dwell,
  output logic                     Y,
  output logic [1:0]               G,
  output logic [1:0]               R,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] region;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic               push, pop, empty, full;

  state_t             state, state_d;
  logic [DWELL_W-1:0] cnt, cnt_d, dwell_load;
  logic [3:0]         gcnt, gcnt_d;
  logic               y_d, done_d;
  logic [1:0]         g_d, r_d;

  // ---------------- FIFO ----------------
  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign req_ready = !full && !clr;
  assign push      = req_valid && req_ready;
  assign head      = mem[rd_ptr];

  // NOTE: the storage array carries no reset; only pointers and level define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{mode: req_mode, region: req_region};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      gcnt  <= gcnt_d;
    end
  end

  // A dwell of zero is presented for a single cycle.
  assign dwell_load = (dwell == '0) ? '0 : dwell - 1'b1;

  // ---------------- FSM: next state ----------------
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    gcnt_d  = gcnt;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_ACTIVE;
          cnt_d   = dwell_load;
        end
      end
      S_ACTIVE: begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else if (GAP_CYCLES > 0) begin
          state_d = S_GAP;
          gcnt_d  = GAP_LOAD;
        end else if (!empty) begin
          pop     = 1'b1;
          cnt_d   = dwell_load;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gcnt != '0) begin
          gcnt_d = gcnt - 1'b1;
        end else if (!empty) begin
          pop     = 1'b1;
          state_d = S_ACTIVE;
          cnt_d   = dwell_load;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush overrides push, pop and the end of a dwell.
    if (clr) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      gcnt_d  = '0;
      pop     = 1'b0;
    end
  end

  // ---------------- FSM: outputs (next values, registered below) ----------------
  always_comb begin
    y_d    = 1'b0;
    g_d    = 2'b00;
    r_d    = 2'b00;
    done_d = (state == S_ACTIVE) && (cnt == '0) && !clr;
    if (pop) begin
      y_d = 1'b1;
      g_d = head.mode;
      r_d = head.region;
    end else if (state_d == S_ACTIVE) begin
      y_d = 1'b1;
      g_d = G;
      r_d = R;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y    <= 1'b0;
      G    <= 2'b00;
      R    <= 2'b00;
      done <= 1'b0;
    end else begin
      Y    <= y_d;
      G    <= g_d;
      R    <= r_d;
      done <= done_d;
    end
  end

endmodule
